// File: rtl/nroot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nroot_pkg
// Brief    : Shared constants and helpers for the Nroot/Taylor datapath.
// Revision : 1.0  initial release
// ============================================================================
package nroot_pkg;

  // Width of one serial slice handled by the nibble adder
  localparam int NIB_W = 4;

  // Serial adder FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits needed to count 0..value-1; never less than one bit
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage : nroot_pkg
`default_nettype wire

// File: rtl/nibble_serial_adder_fa4.sv
`default_nettype none
// ============================================================================
// Module   : FA_4
// Brief    : 4-bit full adder slice: s/cout = a + b + cin.
// Revision : 1.0  initial release
// ============================================================================
module FA_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] total;

  // Plain 5-bit add; the top bit is the slice carry
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  end

  assign s    = total[3:0];
  assign cout = total[4];

endmodule : FA_4
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder
// Brief    : DATA_WIDTH-bit adder that pushes one nibble per cycle through a
//            single 4-bit adder with a registered inter-nibble carry.
//            Valid/ready handshakes on both operand and result sides.
// Revision : 1.0  initial release
// ============================================================================
module nibble_serial_adder
  import nroot_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int NIB   = DATA_WIDTH / NIB_W;
  localparam int CNT_W = clog2(NIB);

  // Reject widths that do not split into whole nibbles
  generate
    if (((DATA_WIDTH % NIB_W) != 0) || (DATA_WIDTH < NIB_W)) begin : g_width_check
      $error("nibble_serial_adder: DATA_WIDTH must be a positive multiple of 4");
    end
  endgenerate

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] a_sh;
  logic [DATA_WIDTH-1:0] b_sh;
  logic [DATA_WIDTH-1:0] sum_sh;
  logic [DATA_WIDTH-1:0] sum_sh_nxt;
  logic                  c_reg;
  logic                  a_msb;
  logic                  b_msb;
  logic [NIB_W-1:0]      fa_s;
  logic                  fa_cout;
  logic                  accept;
  logic                  last_nib;

  assign accept   = in_valid && in_ready;
  assign last_nib = (cnt == CNT_W'(NIB - 1));

  // The one adder slice: always fed the low nibble of the operand shifters
  FA_4 u_fa4 (
    .a    (a_sh[NIB_W-1:0]),
    .b    (b_sh[NIB_W-1:0]),
    .cin  (c_reg),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // New nibble enters at the top of the sum shifter; a single-nibble
  // adder simply replaces the whole register
  generate
    if (NIB == 1) begin : g_sum_single
      assign sum_sh_nxt = fa_s;
    end else begin : g_sum_multi
      assign sum_sh_nxt = {fa_s, sum_sh[DATA_WIDTH-1:NIB_W]};
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE on last nibble,
  // DONE -> IDLE on result handshake
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)    state_nxt = ST_RUN;
      ST_RUN:  if (last_nib)  state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, nibble shifting, carry chaining and counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      c_reg  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      c_reg <= cin;
      a_msb <= a[DATA_WIDTH-1];
      b_msb <= b[DATA_WIDTH-1];
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      a_sh   <= a_sh >> NIB_W;
      b_sh   <= b_sh >> NIB_W;
      sum_sh <= sum_sh_nxt;
      c_reg  <= fa_cout;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  assign sum  = sum_sh;
  assign cout = c_reg;
  assign ovf  = (a_msb == b_msb) && (sum_sh[DATA_WIDTH-1] != a_msb);

endmodule : nibble_serial_adder
`default_nettype wire
